// File: rtl/sram_apb_ctrl_if.sv
// APB slave-side bus bundle for sram_apb_ctrl.
// Signal names follow the APB protocol; the controller uses the slave modport.
interface sram_apb_ctrl_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [AWIDTH+2:0] PADDR;
   logic [DWIDTH-1:0] PWDATA;
   logic [DWIDTH-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/sram_apb_ctrl.sv
// APB front end for a two-port SRAM: word-addressed window with a read wait state,
// plus a small register bank driving a whole-array fill engine on port A.
module sram_apb_ctrl #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   sram_apb_ctrl_if.slave    apb,
   output logic              SRAM_ENA,
   output logic              SRAM_WEA,
   output logic [AWIDTH-1:0] SRAM_ADDRA,
   output logic [DWIDTH-1:0] SRAM_DINA,
   output logic              SRAM_ENB,
   output logic [AWIDTH-1:0] SRAM_ADDRB,
   input  logic [DWIDTH-1:0] SRAM_DOUTB
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_FILL    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [AWIDTH:0]   cnt_q, cnt_d;
   logic [DWIDTH-1:0] fill_q, fill_d;
   logic              done_q, done_d;

   logic              access;
   logic              is_reg;
   logic              busy;
   logic              last_word;
   logic [AWIDTH-1:0] word_addr;
   logic [3:0]        reg_offset;

   assign access     = apb.PSEL & apb.PENABLE;
   assign is_reg     = apb.PADDR[AWIDTH+2];
   assign word_addr  = apb.PADDR[AWIDTH+1:2];
   assign reg_offset = apb.PADDR[3:0];
   assign busy       = (state_q == S_FILL);
   // The counter MSB never sets because the fill ends on the low bits all ones.
   assign last_word  = (&cnt_q[AWIDTH-1:0]) & ~cnt_q[AWIDTH];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_d      = fill_q;
      done_d      = done_q;
      apb.PRDATA  = '0;
      apb.PREADY  = 1'b1;
      apb.PSLVERR = 1'b0;
      SRAM_ENA    = 1'b0;
      SRAM_WEA    = 1'b0;
      SRAM_ADDRA  = '0;
      SRAM_DINA   = '0;
      SRAM_ENB    = 1'b0;
      SRAM_ADDRB  = '0;

      case (state_q)
         S_RD_WAIT: begin
            if (access) begin
               apb.PRDATA = SRAM_DOUTB;
            end
            state_d = S_IDLE;
         end
         S_FILL: begin
            SRAM_ENA   = 1'b1;
            SRAM_WEA   = 1'b1;
            SRAM_ADDRA = cnt_q[AWIDTH-1:0];
            SRAM_DINA  = fill_q;
            cnt_d      = cnt_q + 1'b1;
            if (last_word) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
            // Window accesses stall without touching the SRAM until the fill ends.
            if (access && !is_reg) begin
               apb.PREADY = 1'b0;
            end
         end
         default: begin
            if (access && !is_reg) begin
               if (apb.PWRITE) begin
                  SRAM_ENA   = 1'b1;
                  SRAM_WEA   = 1'b1;
                  SRAM_ADDRA = word_addr;
                  SRAM_DINA  = apb.PWDATA;
               end else begin
                  SRAM_ENB   = 1'b1;
                  SRAM_ADDRB = word_addr;
                  apb.PREADY = 1'b0;
                  state_d    = S_RD_WAIT;
               end
            end
         end
      endcase

      // Register bank answers with zero wait in every state.
      if (access && is_reg) begin
         case (reg_offset)
            4'h0: begin
               if (apb.PWRITE) begin
                  if (apb.PWDATA[1]) begin
                     done_d = 1'b0;
                  end
                  if (apb.PWDATA[0]) begin
                     if (busy) begin
                        apb.PSLVERR = 1'b1;
                     end else begin
                        state_d = S_FILL;
                        cnt_d   = '0;
                     end
                  end
               end
            end
            4'h4: begin
               if (!apb.PWRITE) begin
                  apb.PRDATA = {{(DWIDTH-2){1'b0}}, done_q, busy};
               end
            end
            4'h8: begin
               if (apb.PWRITE) begin
                  fill_d = apb.PWDATA;
               end else begin
                  apb.PRDATA = fill_q;
               end
            end
            default: begin
               apb.PSLVERR = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         fill_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_sram_apb_ctrl.sv
// Self-checking bench for sram_apb_ctrl: behavioural SRAM attached to the ports,
// randomized APB traffic checked against a word-array reference model.
module tb_sram_apb_ctrl;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 1 << AW;
   localparam logic [7:0] A_CTRL   = 8'h80;
   localparam logic [7:0] A_STATUS = 8'h84;
   localparam logic [7:0] A_FILL   = 8'h88;
   localparam logic [7:0] A_BAD    = 8'h8C;

   logic          clk;
   logic          rst_n;
   logic          sram_ena, sram_wea, sram_enb;
   logic [AW-1:0] sram_addra, sram_addrb;
   logic [DW-1:0] sram_dina, sram_doutb;

   int tests = 0;
   int errs  = 0;
   int wr_count = 0;

   logic [DW-1:0] sram_mem [DEPTH];
   logic [DW-1:0] ref_mem  [DEPTH];

   sram_apb_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   sram_apb_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .PCLK       (clk),
      .PRESETn    (rst_n),
      .apb        (bus),
      .SRAM_ENA   (sram_ena),
      .SRAM_WEA   (sram_wea),
      .SRAM_ADDRA (sram_addra),
      .SRAM_DINA  (sram_dina),
      .SRAM_ENB   (sram_enb),
      .SRAM_ADDRB (sram_addrb),
      .SRAM_DOUTB (sram_doutb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-port SRAM with registered read, as seen by the controller.
   always @(posedge clk) begin
      if (sram_ena && sram_wea) sram_mem[sram_addra] <= sram_dina;
      if (sram_enb) sram_doutb <= sram_mem[sram_addrb];
   end

   always @(negedge clk) begin
      if (sram_ena === 1'b1 && sram_wea === 1'b1) wr_count <= wr_count + 1;
   end

   task automatic apb(input logic wr, input logic [7:0] addr, input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd, output logic err, output int waits);
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      waits = 0;
      @(negedge clk);
      while (bus.PREADY !== 1'b1 && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (bus.PREADY !== 1'b1) begin
         tests++; errs++;
         $display("FAIL apb_timeout: addr %h PREADY=%b, required 1 within 200 cycles", addr, bus.PREADY);
      end
      rd  = bus.PRDATA;
      err = bus.PSLVERR;
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      $display("[TB] %s addr=%h wdata=%h rdata=%h err=%0b waits=%0d",
               wr ? "WR" : "RD", addr, wd, rd, err, waits);
   endtask

   task automatic test_reset();
      logic [DW-1:0] rd; logic err; int w;
      rst_n = 1'b0;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (bus.PREADY !== 1'b1) begin errs++; $display("FAIL reset_pready: got %b expected 1", bus.PREADY); end
      tests++; if (bus.PRDATA !== '0) begin errs++; $display("FAIL reset_prdata: got %h expected 0", bus.PRDATA); end
      tests++; if (bus.PSLVERR !== 1'b0) begin errs++; $display("FAIL reset_pslverr: got %b expected 0", bus.PSLVERR); end
      tests++;
      if ({sram_ena, sram_wea, sram_enb, sram_addra, sram_addrb, sram_dina} !== '0) begin
         errs++; $display("FAIL reset_sram_ports: got ena=%b wea=%b enb=%b addra=%h addrb=%h dina=%h expected all 0",
                          sram_ena, sram_wea, sram_enb, sram_addra, sram_addrb, sram_dina);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      apb(1'b0, A_STATUS, '0, rd, err, w);
      tests++; if (rd !== 32'h0) begin errs++; $display("FAIL reset_status: got %h expected 0", rd); end
      apb(1'b0, A_FILL, '0, rd, err, w);
      tests++; if (rd !== 32'h0) begin errs++; $display("FAIL reset_fill: got %h expected 0", rd); end
   endtask

   task automatic test_sram_rw();
      logic [DW-1:0] rd, d; logic err; int w; logic [AW-1:0] a; logic wr;
      apb(1'b1, {1'b0, 5'd3, 2'b00}, 32'hDEADBEEF, rd, err, w);
      ref_mem[3] = 32'hDEADBEEF;
      tests++; if (w != 0 || err !== 1'b0) begin errs++; $display("FAIL rw_write_wait: got waits=%0d err=%b expected 0/0", w, err); end
      apb(1'b0, {1'b0, 5'd3, 2'b00}, '0, rd, err, w);
      tests++; if (w != 1) begin errs++; $display("FAIL rw_read_wait: got %0d expected 1", w); end
      tests++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL rw_read_data: got %h expected deadbeef", rd); end
      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         apb(1'b1, {1'b0, 5'(i), 2'($urandom)}, d, rd, err, w);
         ref_mem[i] = d;
         tests++; if (w != 0) begin errs++; $display("FAIL rw_init_wait: word %0d got %0d expected 0", i, w); end
      end
      for (int i = 0; i < 24; i++) begin
         a  = 5'($urandom);
         wr = 1'($urandom);
         d  = $urandom;
         apb(wr, {1'b0, a, 2'($urandom)}, d, rd, err, w);
         if (wr) begin
            ref_mem[a] = d;
            tests++; if (w != 0) begin errs++; $display("FAIL rw_rand_wwait: got %0d expected 0", w); end
         end else begin
            tests++;
            if (rd !== ref_mem[a] || w != 1) begin
               errs++; $display("FAIL rw_rand_read: word %0d got %h/%0d waits expected %h/1", a, rd, w, ref_mem[a]);
            end
         end
      end
   endtask

   task automatic test_fill();
      logic [DW-1:0] rd; logic err; int w;
      logic [DW-1:0] pat;
      pat = 32'hA5A5A5A5;
      apb(1'b1, A_FILL, pat, rd, err, w);
      apb(1'b0, A_FILL, '0, rd, err, w);
      tests++; if (rd !== pat) begin errs++; $display("FAIL fill_reg: got %h expected %h", rd, pat); end
      apb(1'b1, A_CTRL, 32'h1, rd, err, w);
      tests++; if (err !== 1'b0 || w != 0) begin errs++; $display("FAIL fill_start: got err=%b waits=%0d expected 0/0", err, w); end
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         tests++;
         if (sram_ena !== 1'b1 || sram_wea !== 1'b1 || sram_addra !== 5'(i) || sram_dina !== pat) begin
            errs++; $display("FAIL fill_cycle: cycle %0d got ena=%b wea=%b addr=%h din=%h expected 1/1/%h/%h",
                             i, sram_ena, sram_wea, sram_addra, sram_dina, 5'(i), pat);
         end
      end
      @(negedge clk);
      tests++; if (sram_ena !== 1'b0) begin errs++; $display("FAIL fill_end: ena got %b expected 0", sram_ena); end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat;
      apb(1'b0, A_STATUS, '0, rd, err, w);
      tests++; if (rd !== 32'h2) begin errs++; $display("FAIL fill_status: got %h expected 2", rd); end
      for (int i = 0; i < DEPTH; i++) begin
         apb(1'b0, {1'b0, 5'(i), 2'b00}, '0, rd, err, w);
         tests++; if (rd !== ref_mem[i]) begin errs++; $display("FAIL fill_readback: word %0d got %h expected %h", i, rd, ref_mem[i]); end
      end
   endtask

   task automatic test_fill_stall();
      logic [DW-1:0] rd; logic err; int w;
      logic [DW-1:0] pat;
      pat = $urandom;
      apb(1'b1, A_FILL, pat, rd, err, w);
      apb(1'b1, A_CTRL, 32'h3, rd, err, w);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat;
      // Access phase begins two cycles into the fill; held through the rest plus the read wait.
      apb(1'b0, {1'b0, 5'd17, 2'b00}, '0, rd, err, w);
      tests++; if (w != 31) begin errs++; $display("FAIL stall_waits: got %0d expected 31", w); end
      tests++; if (rd !== pat) begin errs++; $display("FAIL stall_data: got %h expected %h", rd, pat); end
   endtask

   task automatic test_busy_start();
      logic [DW-1:0] rd; logic err; int w; int base;
      logic [DW-1:0] pat;
      pat = $urandom;
      apb(1'b1, A_FILL, pat, rd, err, w);
      base = wr_count;
      apb(1'b1, A_CTRL, 32'h3, rd, err, w);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat;
      apb(1'b1, A_CTRL, 32'h1, rd, err, w);
      tests++; if (err !== 1'b1 || w != 0) begin errs++; $display("FAIL busy_start_err: got err=%b waits=%0d expected 1/0", err, w); end
      apb(1'b0, A_STATUS, '0, rd, err, w);
      tests++; if (rd !== 32'h1 || w != 0) begin errs++; $display("FAIL busy_status: got %h waits=%0d expected 1/0", rd, w); end
      repeat (40) @(posedge clk);
      tests++; if (wr_count - base != DEPTH) begin errs++; $display("FAIL busy_fill_len: got %0d expected %0d", wr_count - base, DEPTH); end
      apb(1'b0, A_STATUS, '0, rd, err, w);
      tests++; if (rd !== 32'h2) begin errs++; $display("FAIL busy_done: got %h expected 2", rd); end
   endtask

   task automatic test_reg_err();
      logic [DW-1:0] rd; logic err; int w;
      apb(1'b0, A_BAD, '0, rd, err, w);
      tests++; if (err !== 1'b1 || rd !== '0) begin errs++; $display("FAIL reg_bad_read: got err=%b data=%h expected 1/0", err, rd); end
      apb(1'b1, A_BAD, 32'hFFFFFFFF, rd, err, w);
      tests++; if (err !== 1'b1) begin errs++; $display("FAIL reg_bad_write: got err=%b expected 1", err); end
      apb(1'b0, A_CTRL, '0, rd, err, w);
      tests++; if (err !== 1'b0 || rd !== '0) begin errs++; $display("FAIL reg_ctrl_read: got err=%b data=%h expected 0/0", err, rd); end
      apb(1'b1, A_CTRL, 32'h2, rd, err, w);
      apb(1'b0, A_STATUS, '0, rd, err, w);
      tests++; if (rd !== 32'h0) begin errs++; $display("FAIL reg_done_clr: got %h expected 0", rd); end
   endtask

   task automatic test_reset_midfill();
      logic [DW-1:0] rd; logic err; int w;
      logic [DW-1:0] pat;
      pat = ~ref_mem[0];
      apb(1'b1, A_FILL, pat, rd, err, w);
      apb(1'b1, A_CTRL, 32'h1, rd, err, w);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (sram_ena !== 1'b0 || sram_wea !== 1'b0 || sram_addra !== '0 || sram_dina !== '0 || bus.PREADY !== 1'b1) begin
         errs++; $display("FAIL midfill_reset_outputs: got ena=%b wea=%b addr=%h din=%h pready=%b expected 0/0/0/0/1",
                          sram_ena, sram_wea, sram_addra, sram_dina, bus.PREADY);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) ref_mem[i] = pat;
      apb(1'b0, A_STATUS, '0, rd, err, w);
      tests++; if (rd !== 32'h0) begin errs++; $display("FAIL midfill_status: got %h expected 0", rd); end
      apb(1'b0, A_FILL, '0, rd, err, w);
      tests++; if (rd !== 32'h0) begin errs++; $display("FAIL midfill_fillreg: got %h expected 0", rd); end
      for (int i = 0; i < DEPTH; i++) begin
         apb(1'b0, {1'b0, 5'(i), 2'b00}, '0, rd, err, w);
         tests++; if (rd !== ref_mem[i]) begin errs++; $display("FAIL midfill_word: word %0d got %h expected %h", i, rd, ref_mem[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_sram_rw();
      test_fill();
      test_fill_stall();
      test_busy_start();
      test_reg_err();
      test_reset_midfill();
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
